// File: rtl/kerbin_pkg.sv
// Shared types and the SoC address map for the Kerbin interconnect arbiter.
// The top module reads its default parameters from this package.
package kerbin_pkg;

  localparam int unsigned NR_MASTERS_SOC    = 3;
  localparam int unsigned NR_SLAVES_SOC     = 2;
  localparam int unsigned ADDR_WIDTH_SOC    = 64;
  localparam int unsigned MST_ID_WIDTH_SOC  = 4;
  localparam int unsigned MST_IDX_WIDTH_SOC = $clog2(NR_MASTERS_SOC);
  localparam int unsigned SLV_ID_WIDTH_SOC  = MST_ID_WIDTH_SOC + MST_IDX_WIDTH_SOC;

  localparam logic [ADDR_WIDTH_SOC-1:0] PERIPHERALS_START = 64'h0000_0000_1A00_0000;
  localparam logic [ADDR_WIDTH_SOC-1:0] PERIPHERALS_END   = 64'h0000_0000_1A00_1FFF;
  localparam logic [ADDR_WIDTH_SOC-1:0] L2_START          = 64'h0000_0000_8000_0000;
  localparam logic [ADDR_WIDTH_SOC-1:0] L2_END            = 64'h0000_0000_8007_FFFF;

  typedef struct packed {
    logic [ADDR_WIDTH_SOC-1:0] start_addr;
    logic [ADDR_WIDTH_SOC-1:0] end_addr;
  } addr_rule_t;

  // Slave 0 is the peripheral window, slave 1 is L2; both bounds are inclusive.
  localparam addr_rule_t [NR_SLAVES_SOC-1:0] SOC_ADDR_MAP = '{
    '{start_addr: L2_START,          end_addr: L2_END},
    '{start_addr: PERIPHERALS_START, end_addr: PERIPHERALS_END}
  };

  typedef struct packed {
    logic [MST_IDX_WIDTH_SOC-1:0] mst_idx;
    logic [MST_ID_WIDTH_SOC-1:0]  mst_id;
  } soc_id_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/kerbin_rr_arbiter.sv
// Round-robin picker: first requester at or after the pointer, wrapping.
// The pointer moves to one past the index given on advance.
module kerbin_rr_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  input  logic [IDX_W-1:0] advance_idx,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W:0]   cand;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (!any && req[cand[IDX_W-1:0]]) begin
        any                   = 1'b1;
        idx                   = cand[IDX_W-1:0];
        gnt[cand[IDX_W-1:0]]  = 1'b1;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (advance_idx == IDX_W'(N-1)) ? '0 : advance_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/kerbin_soc_req_arbiter.sv
// Address-channel arbiter/decoder: round-robin grant, address-map decode,
// ID widening and a per-slave cap on outstanding transactions.
module kerbin_soc_req_arbiter
  import kerbin_pkg::*;
#(
  parameter int unsigned NR_MASTERS      = NR_MASTERS_SOC,
  parameter int unsigned NR_SLAVES       = NR_SLAVES_SOC,
  parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_SOC,
  parameter int unsigned MST_ID_WIDTH    = MST_ID_WIDTH_SOC,
  parameter int unsigned SLV_ID_WIDTH    = MST_ID_WIDTH + $clog2(NR_MASTERS),
  parameter logic [NR_SLAVES-1:0][ADDR_WIDTH-1:0] START_ADDR =
    {SOC_ADDR_MAP[1].start_addr, SOC_ADDR_MAP[0].start_addr},
  parameter logic [NR_SLAVES-1:0][ADDR_WIDTH-1:0] END_ADDR =
    {SOC_ADDR_MAP[1].end_addr, SOC_ADDR_MAP[0].end_addr},
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NR_MASTERS-1:0]              req_valid_i,
  output logic [NR_MASTERS-1:0]              req_ready_o,
  input  logic [NR_MASTERS*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NR_MASTERS*MST_ID_WIDTH-1:0] req_id_i,
  output logic [NR_SLAVES-1:0]               slv_valid_o,
  input  logic [NR_SLAVES-1:0]               slv_ready_i,
  output logic [ADDR_WIDTH-1:0]              slv_addr_o,
  output logic [SLV_ID_WIDTH-1:0]            slv_id_o,
  output logic                               err_valid_o,
  input  logic                               err_ready_i,
  input  logic [NR_SLAVES-1:0]               rsp_done_i
);

  localparam int unsigned IDX_W = $clog2(NR_MASTERS);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  arb_state_e              state;
  logic [IDX_W-1:0]        winner;
  logic [IDX_W-1:0]        arb_idx;
  logic [NR_MASTERS-1:0]   arb_gnt;
  logic                    arb_any;
  logic [ADDR_WIDTH-1:0]   pick_addr;
  logic [MST_ID_WIDTH-1:0] pick_id;
  logic [NR_SLAVES-1:0]    dec_slv;
  logic                    dec_err;
  logic [NR_SLAVES-1:0]    tgt_slv;
  logic [NR_SLAVES-1:0]    hs_slv;
  logic                    hs_err;
  logic                    hs;
  logic [NR_SLAVES-1:0]    cnt_ok;
  logic [CNT_W-1:0]        cnt   [NR_SLAVES];
  logic [CNT_W-1:0]        cnt_d [NR_SLAVES];

  kerbin_rr_arbiter #(
    .N     (NR_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .clk         (clk_i),
    .rst         (rst_i),
    .req         (req_valid_i),
    .advance     (hs),
    .advance_idx (winner),
    .gnt         (arb_gnt),
    .idx         (arb_idx),
    .any         (arb_any)
  );

  always_comb begin
    pick_addr = '0;
    pick_id   = '0;
    for (int m = 0; m < NR_MASTERS; m++) begin
      if (arb_gnt[m]) begin
        pick_addr = req_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH];
        pick_id   = req_id_i[m*MST_ID_WIDTH +: MST_ID_WIDTH];
      end
    end
  end

  // Scanning from the top down lets the lowest matching rule win on overlap.
  always_comb begin
    dec_slv = '0;
    for (int s = NR_SLAVES - 1; s >= 0; s--) begin
      if (pick_addr >= START_ADDR[s] && pick_addr <= END_ADDR[s]) begin
        dec_slv    = '0;
        dec_slv[s] = 1'b1;
      end
    end
  end

  assign dec_err = ~|dec_slv;
  assign hs_slv  = slv_valid_o & slv_ready_i;
  assign hs_err  = err_valid_o & err_ready_i;
  assign hs      = (|hs_slv) | hs_err;

  always_comb begin
    req_ready_o = '0;
    if (hs) req_ready_o[winner] = 1'b1;
  end

  // A completion at zero is dropped; a grant plus a completion cancel out.
  always_comb begin
    cnt_ok = '0;
    for (int s = 0; s < NR_SLAVES; s++) begin
      cnt_d[s] = cnt[s];
      unique case ({hs_slv[s], rsp_done_i[s] && (cnt[s] != '0)})
        2'b10:   cnt_d[s] = cnt[s] + CNT_W'(1);
        2'b01:   cnt_d[s] = cnt[s] - CNT_W'(1);
        default: cnt_d[s] = cnt[s];
      endcase
      cnt_ok[s] = (cnt_d[s] < MAX_CNT);
    end
  end

  // NOTE: the counter array is a handful of flops, so it is cleared by reset like any other state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < NR_SLAVES; s++) cnt[s] <= '0;
    end else begin
      for (int s = 0; s < NR_SLAVES; s++) cnt[s] <= cnt_d[s];
    end
  end

  // Valids are registered from the next counter value so the cap holds on the very next cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      winner      <= '0;
      tgt_slv     <= '0;
      slv_valid_o <= '0;
      err_valid_o <= 1'b0;
      slv_addr_o  <= '0;
      slv_id_o    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            state       <= ST_HOLD;
            winner      <= arb_idx;
            tgt_slv     <= dec_slv;
            slv_addr_o  <= pick_addr;
            slv_id_o    <= {arb_idx, pick_id};
            slv_valid_o <= dec_slv & cnt_ok;
            err_valid_o <= dec_err;
          end
        end
        ST_HOLD: begin
          if (hs) begin
            state       <= ST_IDLE;
            tgt_slv     <= '0;
            slv_valid_o <= '0;
            err_valid_o <= 1'b0;
          end else begin
            slv_valid_o <= tgt_slv & cnt_ok;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_grant_held: assert property (@(posedge clk_i) disable iff (rst_i)
    (state == ST_HOLD) |-> req_valid_i[winner]);

  for (genvar s = 0; s < NR_SLAVES; s++) begin : g_done_chk
    a_done_nonzero: assert property (@(posedge clk_i) disable iff (rst_i)
      rsp_done_i[s] |-> (cnt[s] != '0));
  end

endmodule

// File: tb/tb_kerbin_soc_req_arbiter.sv
// Directed bench for kerbin_soc_req_arbiter: reset, decode, fairness,
// outstanding cap, simultaneous grant/completion and backpressure.
module tb_kerbin_soc_req_arbiter;
  import kerbin_pkg::*;

  localparam int NM = 3;
  localparam int NS = 2;
  localparam int AW = 64;
  localparam int IW = 4;
  localparam int SW = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     req_valid;
  logic [NM-1:0]     req_ready;
  logic [NM*AW-1:0]  req_addr;
  logic [NM*IW-1:0]  req_id;
  logic [NS-1:0]     slv_valid;
  logic [NS-1:0]     slv_ready;
  logic [AW-1:0]     slv_addr;
  logic [SW-1:0]     slv_id;
  logic              err_valid;
  logic              err_ready;
  logic [NS-1:0]     rsp_done;

  int vectors     = 0;
  int miscompares = 0;

  kerbin_soc_req_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_id_i    (req_id),
    .slv_valid_o (slv_valid),
    .slv_ready_i (slv_ready),
    .slv_addr_o  (slv_addr),
    .slv_id_o    (slv_id),
    .err_valid_o (err_valid),
    .err_ready_i (err_ready),
    .rsp_done_i  (rsp_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_id    = '0;
    slv_ready = '0;
    err_ready = 1'b0;
    rsp_done  = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int m, input logic [AW-1:0] a, input logic [IW-1:0] id);
    req_valid[m]          = 1'b1;
    req_addr[m*AW +: AW]  = a;
    req_id[m*IW +: IW]    = id;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({slv_valid, err_valid, req_ready} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_valids: got %b want 000000", {slv_valid, err_valid, req_ready});
    end
    vectors++;
    if (slv_addr !== 64'h0 || slv_id !== 6'h0) begin
      miscompares++;
      $display("FAIL reset_data: got addr %h id %h want 0 0", slv_addr, slv_id);
    end
  endtask

  task automatic test_decode();
    logic [AW-1:0] addrs [7] = '{64'h8000_0000, 64'h1A00_1FFF, 64'h1A00_2000, 64'h1A00_0000,
                                 64'h8007_FFFF, 64'h8008_0000, 64'h19FF_FFFF};
    logic [2:0]    tgts  [7] = '{3'b100, 3'b010, 3'b001, 3'b010, 3'b100, 3'b001, 3'b001};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      req_valid = '0;
      set_req(0, addrs[i], 4'h3);
      tick();
      vectors++;
      if ({slv_valid, err_valid} !== tgts[i] || slv_addr !== addrs[i] || slv_id !== 6'h03) begin
        miscompares++;
        $display("FAIL decode_%0d: got tgt %b addr %h id %h want tgt %b addr %h id 03",
                 i, {slv_valid, err_valid}, slv_addr, slv_id, tgts[i], addrs[i]);
      end
      slv_ready = 2'b11;
      err_ready = 1'b1;
      #1;
      vectors++;
      if (req_ready !== 3'b001) begin
        miscompares++;
        $display("FAIL decode_ready_%0d: got %b want 001", i, req_ready);
      end
      tick();
      req_valid = '0;
      slv_ready = '0;
      err_ready = 1'b0;
    end
  endtask

  task automatic test_fairness();
    logic [IW-1:0] ids  [3] = '{4'h1, 4'h2, 4'h3};
    logic [2:0]    tgts [3] = '{3'b010, 3'b100, 3'b001};
    soc_id_t       exp_id;
    int            m;
    apply_reset();
    slv_ready = 2'b11;
    err_ready = 1'b1;
    set_req(0, 64'h1A00_0100, ids[0]);
    set_req(1, 64'h8000_0100, ids[1]);
    set_req(2, 64'h0000_1000, ids[2]);
    for (int i = 0; i < 4; i++) begin
      m = i % 3;
      exp_id.mst_idx = 2'(m);
      exp_id.mst_id  = ids[m];
      tick();
      vectors++;
      if (req_ready !== (3'b001 << m) || {slv_valid, err_valid} !== tgts[m]) begin
        miscompares++;
        $display("FAIL fair_grant_%0d: got ready %b tgt %b want ready %b tgt %b",
                 i, req_ready, {slv_valid, err_valid}, 3'b001 << m, tgts[m]);
      end
      vectors++;
      if (slv_id !== exp_id) begin
        miscompares++;
        $display("FAIL fair_id_%0d: got %h want %h", i, slv_id, exp_id);
      end
      tick();
      vectors++;
      if (req_ready !== 3'b000) begin
        miscompares++;
        $display("FAIL fair_gap_%0d: got %b want 000", i, req_ready);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_outstanding();
    apply_reset();
    slv_ready = 2'b11;
    set_req(0, 64'h8000_0200, 4'h9);
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (req_ready !== 3'b001 || slv_valid !== 2'b10) begin
        miscompares++;
        $display("FAIL limit_accept_%0d: got ready %b valid %b want 001 10", i, req_ready, slv_valid);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (slv_valid !== 2'b00 || req_ready !== 3'b000) begin
        miscompares++;
        $display("FAIL limit_held_%0d: got valid %b ready %b want 00 000", i, slv_valid, req_ready);
      end
    end
    rsp_done = 2'b10;
    tick();
    rsp_done = 2'b00;
    #1;
    vectors++;
    if (slv_valid !== 2'b10 || req_ready !== 3'b001) begin
      miscompares++;
      $display("FAIL limit_release: got valid %b ready %b want 10 001", slv_valid, req_ready);
    end
    tick();
    req_valid = '0;
  endtask

  task automatic test_simultaneous();
    apply_reset();
    slv_ready = 2'b11;
    set_req(1, 64'h1A00_0040, 4'hA);
    for (int i = 0; i < 2; i++) begin
      tick();
      tick();
    end
    tick();
    rsp_done = 2'b01;
    #1;
    vectors++;
    if (req_ready !== 3'b010) begin
      miscompares++;
      $display("FAIL simul_ready: got %b want 010", req_ready);
    end
    tick();
    rsp_done = 2'b00;
    vectors++;
    if (dut.cnt[0] !== 3'd2) begin
      miscompares++;
      $display("FAIL simul_cnt: got %0d want 2", dut.cnt[0]);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (req_ready !== 3'b010) begin
        miscompares++;
        $display("FAIL simul_fill_%0d: got %b want 010", i, req_ready);
      end
      tick();
    end
    tick();
    vectors++;
    if (slv_valid !== 2'b00 || req_ready !== 3'b000) begin
      miscompares++;
      $display("FAIL simul_full: got valid %b ready %b want 00 000", slv_valid, req_ready);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_req(2, 64'h8000_0040, 4'h5);
    tick();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (slv_valid !== 2'b10 || slv_addr !== 64'h8000_0040 || slv_id !== 6'h25 || req_ready !== 3'b000) begin
        miscompares++;
        $display("FAIL bp_stall_%0d: got valid %b addr %h id %h ready %b want 10 80000040 25 000",
                 i, slv_valid, slv_addr, slv_id, req_ready);
      end
      tick();
    end
    slv_ready = 2'b10;
    #1;
    vectors++;
    if (req_ready !== 3'b100) begin
      miscompares++;
      $display("FAIL bp_release: got %b want 100", req_ready);
    end
    tick();
    req_valid = '0;
    slv_ready = '0;
  endtask

  task automatic test_reset_mid_hold();
    apply_reset();
    slv_ready = 2'b11;
    set_req(0, 64'h1A00_0010, 4'h0);
    tick();
    tick();
    req_valid = '0;
    slv_ready = '0;
    set_req(1, 64'h1A00_0004, 4'h7);
    tick();
    vectors++;
    if (slv_valid !== 2'b01 || slv_id !== 6'h17) begin
      miscompares++;
      $display("FAIL midrst_pre: got valid %b id %h want 01 17", slv_valid, slv_id);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({slv_valid, err_valid, req_ready} !== 6'b0 || slv_addr !== 64'h0 || slv_id !== 6'h0) begin
      miscompares++;
      $display("FAIL midrst_outputs: got tgt %b ready %b addr %h id %h want all 0",
               {slv_valid, err_valid}, req_ready, slv_addr, slv_id);
    end
    vectors++;
    if (dut.cnt[0] !== 3'd0) begin
      miscompares++;
      $display("FAIL midrst_cnt: got %0d want 0", dut.cnt[0]);
    end
    req_valid = '0;
    tick();
    rst = 1'b0;
    slv_ready = 2'b11;
    set_req(0, 64'h1A00_0020, 4'h1);
    set_req(1, 64'h1A00_0004, 4'h7);
    tick();
    vectors++;
    if (slv_id !== 6'h01 || slv_valid !== 2'b01) begin
      miscompares++;
      $display("FAIL midrst_next_grant: got id %h valid %b want 01 01", slv_id, slv_valid);
    end
    tick();
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_fairness();
    test_outstanding();
    test_simultaneous();
    test_backpressure();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
